// File: rtl/lock_pkg.sv
// lock_pkg: shared types and constants for the combination-lock sequencer.
//   state_e     - controller state, also driven out on state_out
//   disp_mode_e - selector consumed by the seven-segment decode logic
//   CODE_LEN    - digits per code, DIGIT_W - bits per digit
//   is_legal_digit() - true for decimal digits 0..9
package lock_pkg;

  localparam int CODE_LEN = 6;
  localparam int DIGIT_W  = 4;

  typedef enum logic [2:0] {
    ENTRY   = 3'd0,
    OPEN    = 3'd1,
    CLOSED  = 3'd2,
    LOCKOUT = 3'd3,
    PROG    = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    DM_DIGIT  = 3'd0,
    DM_OPEN   = 3'd1,
    DM_CLOSED = 3'd2,
    DM_ERROR  = 3'd3,
    DM_LOCKED = 3'd4,
    DM_PROG   = 3'd5
  } disp_mode_e;

  function automatic logic is_legal_digit(input logic [DIGIT_W-1:0] d);
    return d <= 4'd9;
  endfunction

endpackage

// File: rtl/lock_code_store.sv
// lock_code_store: live combination register plus a shadow used while
// re-programming. The live code only changes on a commit, so an aborted
// program pass leaves it untouched.
//   clk, rst_n  - clock, synchronous active-low reset (code <= DEFAULT_CODE)
//   pos         - digit index for both the read and the shadow write
//   wr_en/wr_digit - write wr_digit into shadow[pos]
//   commit      - copy shadow (including this cycle's write) into the live code
//   discard     - drop the shadow contents
//   rd_digit    - live code digit at pos (combinational)
module lock_code_store
  import lock_pkg::*;
#(
  parameter int                           CODE_LEN     = lock_pkg::CODE_LEN,
  parameter logic [CODE_LEN*DIGIT_W-1:0]  DEFAULT_CODE = 24'h703262
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2:0]         pos,
  input  logic               wr_en,
  input  logic [DIGIT_W-1:0] wr_digit,
  input  logic               commit,
  input  logic               discard,
  output logic [DIGIT_W-1:0] rd_digit
);

  logic [CODE_LEN-1:0][DIGIT_W-1:0] code, shadow, shadow_wr;
  logic [2:0]                       idx;

  // First digit lives in the top nibble, so digit pos sits at element LEN-1-pos.
  assign idx      = 3'(CODE_LEN - 1) - pos;
  assign rd_digit = code[idx];

  always_comb begin
    shadow_wr = shadow;
    if (wr_en) shadow_wr[idx] = wr_digit;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      code   <= DEFAULT_CODE;
      shadow <= DEFAULT_CODE;
    end else begin
      shadow <= discard ? code : shadow_wr;
      if (commit) code <= shadow_wr;
    end
  end

endmodule

// File: rtl/lock_sequencer.sv
// lock_sequencer: combination-lock controller. Takes one strobed digit per
// cycle, checks it against the stored code, counts failed attempts, holds a
// timed lockout and allows re-programming the code while open.
//   clk, rst_n            - clock, synchronous active-low reset
//   digit_in, digit_valid - entered digit and its one-cycle strobe
//   clear                 - abandon attempt / leave OPEN or CLOSED / abort PROG
//   prog_req              - enter programming (OPEN only)
//   state_out             - current state (lock_pkg::state_e)
//   disp_mode, disp_digit - display selector and last legal digit
//   pos                   - digits accepted in current attempt or program pass
//   fail_cnt              - consecutive failed attempts
//   unlocked              - high in OPEN and PROG
//   err                   - one-cycle pulse on illegal digit or aborted program
// All outputs are registered.
module lock_sequencer
  import lock_pkg::*;
#(
  parameter int                          CODE_LEN       = lock_pkg::CODE_LEN,
  parameter int                          MAX_FAIL       = 3,
  parameter int                          LOCKOUT_CYCLES = 16,
  parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE   = 24'h703262
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DIGIT_W-1:0] digit_in,
  input  logic               digit_valid,
  input  logic               clear,
  input  logic               prog_req,
  output logic [2:0]         state_out,
  output logic [2:0]         disp_mode,
  output logic [DIGIT_W-1:0] disp_digit,
  output logic [2:0]         pos,
  output logic [1:0]         fail_cnt,
  output logic               unlocked,
  output logic               err
);

  localparam int            TW     = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LOAD = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [2:0]    LAST   = 3'(CODE_LEN - 1);
  localparam logic [1:0]    FMAX   = 2'(MAX_FAIL);

  state_e             state, state_n;
  disp_mode_e         dm_q, dm_n;
  logic [2:0]         pos_n;
  logic [1:0]         fail_n, fail_inc;
  logic [TW-1:0]      timer, timer_n;
  logic               mism, mism_n;
  logic [DIGIT_W-1:0] dd_n, code_digit;
  logic               err_n, legal, hit;
  logic               wr_en, commit, discard;

  lock_code_store #(
    .CODE_LEN     (CODE_LEN),
    .DEFAULT_CODE (DEFAULT_CODE)
  ) u_store (
    .clk      (clk),
    .rst_n    (rst_n),
    .pos      (pos),
    .wr_en    (wr_en),
    .wr_digit (digit_in),
    .commit   (commit),
    .discard  (discard),
    .rd_digit (code_digit)
  );

  always_comb begin
    state_n  = state;
    pos_n    = pos;
    mism_n   = mism;
    fail_n   = fail_cnt;
    timer_n  = timer;
    dm_n     = dm_q;
    dd_n     = disp_digit;
    err_n    = 1'b0;
    wr_en    = 1'b0;
    commit   = 1'b0;
    discard  = 1'b0;
    legal    = is_legal_digit(digit_in);
    hit      = legal && (digit_in == code_digit);
    fail_inc = fail_cnt + 2'd1;

    unique case (state)
      ENTRY: begin
        if (clear) begin
          pos_n  = '0;
          mism_n = 1'b0;
          dm_n   = DM_DIGIT;
        end else if (digit_valid) begin
          if (legal) begin
            dm_n = DM_DIGIT;
            dd_n = digit_in;
          end else begin
            dm_n  = DM_ERROR;
            err_n = 1'b1;
          end
          if (pos == LAST) begin
            // Verdict uses the flag from earlier digits plus this last one.
            pos_n  = '0;
            mism_n = 1'b0;
            if (!mism && hit) begin
              state_n = OPEN;
              fail_n  = '0;
            end else begin
              fail_n = fail_inc;
              if (fail_inc == FMAX) begin
                state_n = LOCKOUT;
                timer_n = T_LOAD;
              end else begin
                state_n = CLOSED;
              end
            end
          end else begin
            pos_n  = pos + 3'd1;
            mism_n = mism | ~hit;
          end
        end
      end
      CLOSED: begin
        if (clear) begin
          state_n = ENTRY;
          dm_n    = DM_DIGIT;
        end
      end
      LOCKOUT: begin
        if (timer == '0) begin
          state_n = ENTRY;
          fail_n  = '0;
          dm_n    = DM_DIGIT;
        end else begin
          timer_n = timer - 1'b1;
        end
      end
      OPEN: begin
        if (clear) begin
          state_n = ENTRY;
          dm_n    = DM_DIGIT;
        end else if (prog_req) begin
          state_n = PROG;
          pos_n   = '0;
        end
      end
      PROG: begin
        if (clear || (digit_valid && !legal)) begin
          discard = 1'b1;
          err_n   = 1'b1;
          state_n = OPEN;
          pos_n   = '0;
        end else if (digit_valid) begin
          wr_en = 1'b1;
          dd_n  = digit_in;
          if (pos == LAST) begin
            commit  = 1'b1;
            state_n = OPEN;
            pos_n   = '0;
          end else begin
            pos_n = pos + 3'd1;
          end
        end
      end
      default: state_n = ENTRY;
    endcase

    // Outside ENTRY the display mode is a pure function of the state.
    case (state_n)
      OPEN:    dm_n = DM_OPEN;
      CLOSED:  dm_n = DM_CLOSED;
      LOCKOUT: dm_n = DM_LOCKED;
      PROG:    dm_n = DM_PROG;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ENTRY;
      pos        <= '0;
      mism       <= 1'b0;
      fail_cnt   <= '0;
      timer      <= '0;
      dm_q       <= DM_DIGIT;
      disp_digit <= '0;
      err        <= 1'b0;
      unlocked   <= 1'b0;
    end else begin
      state      <= state_n;
      pos        <= pos_n;
      mism       <= mism_n;
      fail_cnt   <= fail_n;
      timer      <= timer_n;
      dm_q       <= dm_n;
      disp_digit <= dd_n;
      err        <= err_n;
      unlocked   <= (state_n == OPEN) || (state_n == PROG);
    end
  end

  assign state_out = state;
  assign disp_mode = dm_q;

endmodule

// File: tb/tb_lock_sequencer.sv
module tb_lock_sequencer;
  import lock_pkg::*;

  localparam int LEN  = 6;
  localparam int MAXF = 3;
  localparam int LOCK = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] digit_in = '0;
  logic       digit_valid = 1'b0;
  logic       clear = 1'b0;
  logic       prog_req = 1'b0;
  logic [2:0] state_out, disp_mode, pos;
  logic [3:0] disp_digit;
  logic [1:0] fail_cnt;
  logic       unlocked, err;

  int n_tests = 0;
  int n_fail  = 0;

  lock_sequencer #(
    .CODE_LEN(LEN), .MAX_FAIL(MAXF), .LOCKOUT_CYCLES(LOCK), .DEFAULT_CODE(24'h703262)
  ) dut (
    .clk(clk), .rst_n(rst_n), .digit_in(digit_in), .digit_valid(digit_valid),
    .clear(clear), .prog_req(prog_req), .state_out(state_out), .disp_mode(disp_mode),
    .disp_digit(disp_digit), .pos(pos), .fail_cnt(fail_cnt), .unlocked(unlocked), .err(err)
  );

  always #5 clk = ~clk;

  // Reference model: an attempt is a list of entered digits judged as a whole
  // once it reaches LEN entries; programming collects a new list.
  state_e     m_state;
  disp_mode_e m_dm;
  int         m_code[LEN];
  int         m_att[$];
  int         m_shd[$];
  int         m_fail, m_left, m_dd;
  bit         m_err;

  task automatic m_reset();
    logic [23:0] dc;
    dc = 24'h703262;
    for (int i = 0; i < LEN; i++) m_code[i] = int'(dc[23-4*i -: 4]);
    m_att.delete(); m_shd.delete();
    m_state = ENTRY; m_dm = DM_DIGIT; m_fail = 0; m_left = 0; m_dd = 0; m_err = 0;
  endtask

  task automatic m_step(input bit dv, input int d, input bit clr, input bit pr);
    bit ok;
    m_err = 0;
    case (m_state)
      ENTRY: begin
        if (clr) begin
          m_att.delete(); m_dm = DM_DIGIT;
        end else if (dv) begin
          if (d > 9) begin m_err = 1; m_dm = DM_ERROR; m_att.push_back(-1); end
          else begin m_dm = DM_DIGIT; m_dd = d; m_att.push_back(d); end
          if (m_att.size() == LEN) begin
            ok = 1;
            for (int i = 0; i < LEN; i++) if (m_att[i] != m_code[i]) ok = 0;
            m_att.delete();
            if (ok) begin m_state = OPEN; m_fail = 0; end
            else begin
              m_fail++;
              if (m_fail == MAXF) begin m_state = LOCKOUT; m_left = LOCK; end
              else m_state = CLOSED;
            end
          end
        end
      end
      CLOSED: if (clr) begin m_state = ENTRY; m_dm = DM_DIGIT; end
      LOCKOUT: begin
        m_left--;
        if (m_left == 0) begin m_state = ENTRY; m_fail = 0; m_dm = DM_DIGIT; end
      end
      OPEN: begin
        if (clr) begin m_state = ENTRY; m_dm = DM_DIGIT; end
        else if (pr) begin m_state = PROG; m_shd.delete(); end
      end
      PROG: begin
        if (clr || (dv && d > 9)) begin m_err = 1; m_state = OPEN; m_shd.delete(); end
        else if (dv) begin
          m_dd = d; m_shd.push_back(d);
          if (m_shd.size() == LEN) begin
            for (int i = 0; i < LEN; i++) m_code[i] = m_shd[i];
            m_shd.delete(); m_state = OPEN;
          end
        end
      end
      default: ;
    endcase
    case (m_state)
      OPEN:    m_dm = DM_OPEN;
      CLOSED:  m_dm = DM_CLOSED;
      LOCKOUT: m_dm = DM_LOCKED;
      PROG:    m_dm = DM_PROG;
      default: ;
    endcase
  endtask

  function automatic int m_pos();
    if (m_state == ENTRY) return m_att.size();
    if (m_state == PROG)  return m_shd.size();
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cmp_all();
    chk("state",      32'(state_out),  32'(m_state));
    chk("pos",        32'(pos),        m_pos());
    chk("fail_cnt",   32'(fail_cnt),   m_fail);
    chk("unlocked",   32'(unlocked),   32'(m_state == OPEN || m_state == PROG));
    chk("err",        32'(err),        32'(m_err));
    chk("disp_mode",  32'(disp_mode),  32'(m_dm));
    chk("disp_digit", 32'(disp_digit), m_dd);
  endtask

  task automatic cyc(input logic dv, input logic [3:0] d, input logic clr, input logic pr);
    digit_valid = dv; digit_in = d; clear = clr; prog_req = pr;
    m_step(dv, int'(d), clr, pr);
    @(posedge clk); #1;
    digit_valid = 1'b0; clear = 1'b0; prog_req = 1'b0;
    cmp_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    digit_valid = 1'b1; clear = 1'b1; prog_req = 1'b1; // reset must override strobes
    m_reset();
    @(posedge clk); #1;
    rst_n = 1'b1; digit_valid = 1'b0; clear = 1'b0; prog_req = 1'b0;
    cmp_all();
  endtask

  task automatic enter6(input logic [23:0] c);
    for (int i = 0; i < LEN; i++) cyc(1'b1, c[23-4*i -: 4], 1'b0, 1'b0);
  endtask

  initial begin
    m_reset();
    // Reset state
    do_reset();
    chk("rst_state", 32'(state_out), 32'(ENTRY));
    chk("rst_dmode", 32'(disp_mode), 32'(DM_DIGIT));
    chk("rst_pos", 32'(pos), 0);

    // Default code opens
    enter6(24'h703262);
    chk("open_state", 32'(state_out), 32'(OPEN));
    chk("open_unlk", 32'(unlocked), 1);
    chk("open_dmode", 32'(disp_mode), 32'(DM_OPEN));

    // Wrong last digit, then an illegal digit mid-attempt
    cyc(1'b0, 4'd0, 1'b1, 1'b0);
    enter6(24'h703263);
    chk("wrong_state", 32'(state_out), 32'(CLOSED));
    chk("wrong_fail", 32'(fail_cnt), 1);
    cyc(1'b0, 4'd0, 1'b1, 1'b0);
    chk("clr_state", 32'(state_out), 32'(ENTRY));
    chk("clr_pos", 32'(pos), 0);
    cyc(1'b1, 4'd7, 1'b0, 1'b0);
    cyc(1'b1, 4'd0, 1'b0, 1'b0);
    cyc(1'b1, 4'd3, 1'b0, 1'b0);
    cyc(1'b1, 4'd11, 1'b0, 1'b0);
    chk("ill_err", 32'(err), 1);
    chk("ill_dmode", 32'(disp_mode), 32'(DM_ERROR));
    chk("ill_dd", 32'(disp_digit), 3);
    cyc(1'b1, 4'd2, 1'b0, 1'b0);
    chk("ill_errdrop", 32'(err), 0);
    cyc(1'b1, 4'd6, 1'b0, 1'b0);
    chk("ill_state", 32'(state_out), 32'(CLOSED));
    chk("ill_fail", 32'(fail_cnt), 2);

    // Third failure -> lockout, strobes ignored, exit after exactly LOCK edges
    cyc(1'b0, 4'd0, 1'b1, 1'b0);
    enter6(24'h111111);
    chk("lk_state", 32'(state_out), 32'(LOCKOUT));
    chk("lk_dmode", 32'(disp_mode), 32'(DM_LOCKED));
    for (int k = 1; k <= LOCK; k++) begin
      cyc(1'b1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (k < LOCK) chk("lk_hold", 32'(state_out), 32'(LOCKOUT));
    end
    chk("lk_exit", 32'(state_out), 32'(ENTRY));
    chk("lk_fail0", 32'(fail_cnt), 0);

    // Program a new code
    enter6(24'h703262);
    cyc(1'b0, 4'd0, 1'b0, 1'b1);
    chk("prog_state", 32'(state_out), 32'(PROG));
    enter6(24'h123456);
    chk("prog_done", 32'(state_out), 32'(OPEN));
    cyc(1'b0, 4'd0, 1'b1, 1'b0);
    enter6(24'h123456);
    chk("newcode_open", 32'(state_out), 32'(OPEN));
    cyc(1'b0, 4'd0, 1'b1, 1'b0);
    enter6(24'h703262);
    chk("oldcode_closed", 32'(state_out), 32'(CLOSED));

    // Aborted program pass keeps the old code
    cyc(1'b0, 4'd0, 1'b1, 1'b0);
    enter6(24'h123456);
    cyc(1'b0, 4'd0, 1'b0, 1'b1);
    cyc(1'b1, 4'd9, 1'b0, 1'b0);
    cyc(1'b1, 4'd9, 1'b0, 1'b0);
    cyc(1'b1, 4'd9, 1'b0, 1'b0);
    cyc(1'b1, 4'd12, 1'b0, 1'b0);
    chk("abort_err", 32'(err), 1);
    chk("abort_state", 32'(state_out), 32'(OPEN));
    cyc(1'b0, 4'd0, 1'b1, 1'b0);
    enter6(24'h123456);
    chk("abort_keep", 32'(state_out), 32'(OPEN));

    // Reset mid-program restores the default code
    cyc(1'b0, 4'd0, 1'b0, 1'b1);
    cyc(1'b1, 4'd9, 1'b0, 1'b0);
    cyc(1'b1, 4'd9, 1'b0, 1'b0);
    do_reset();
    chk("rstprog_state", 32'(state_out), 32'(ENTRY));
    enter6(24'h703262);
    chk("rstprog_dflt", 32'(state_out), 32'(OPEN));

    // clear + digit in the same cycle at pos 4 drops the digit and the mismatch
    cyc(1'b0, 4'd0, 1'b1, 1'b0);
    enter6(24'h7032);
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, 4'd1, 1'b0, 1'b0);
    chk("cd_pos4", 32'(pos), 4);
    cyc(1'b1, 4'd6, 1'b1, 1'b0);
    chk("cd_pos0", 32'(pos), 0);
    enter6(24'h703262);
    chk("cd_open", 32'(state_out), 32'(OPEN));

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] d;
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        if (m_state == ENTRY && $urandom_range(0, 1) == 1) d = 4'(m_code[m_pos()]);
        else if ($urandom_range(0, 7) == 0) d = 4'($urandom_range(10, 15));
        else d = 4'($urandom_range(0, 9));
        cyc(1'($urandom_range(0, 1)), d, ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lock_sequencer.md
# lock_sequencer

Controller that sequences the combination-lock datapath: accepts one strobed digit per entry, checks it against a programmable 6-digit code, counts failed attempts, enforces a timed lockout, and supports re-programming the code while open. Sits between the switch/key input conditioning and the seven-segment decode logic, which it drives through a display-mode selector plus the current digit.

## Interface
Parameters:
- CODE_LEN, 6, digits per code (position counter width 3 bits)
- MAX_FAIL, 3, consecutive failed attempts that trigger lockout
- LOCKOUT_CYCLES, 16, clock cycles spent in LOCKOUT
- DEFAULT_CODE, 24'h703262, reset code, 4 bits per digit, first digit in [23:20]

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  reset, synchronous, active-low
- digit_in  in  4  entered digit; legal values 0-9
- digit_valid  in  1  one-cycle strobe: digit_in is sampled this edge
- clear  in  1  one-cycle strobe: abandon the current attempt or leave OPEN/CLOSED
- prog_req  in  1  one-cycle strobe: enter programming; honoured only in OPEN
- state_out  out  3  current state encoding (lock_pkg)
- disp_mode  out  3  DIGIT / OPEN / CLOSED / ERROR / LOCKED / PROG
- disp_digit  out  4  last legal digit accepted
- pos  out  3  digits accepted in current attempt or program pass, 0..CODE_LEN-1
- fail_cnt  out  2  consecutive failed attempts
- unlocked  out  1  high in OPEN and PROG
- err  out  1  one-cycle pulse on an illegal digit or aborted program pass

## Operation
- Reset: state ENTRY, pos 0, mismatch flag 0, fail_cnt 0, code = DEFAULT_CODE, disp_mode DIGIT, disp_digit 0, unlocked 0, err 0, lockout timer 0.
- ENTRY, digit_valid: compare digit_in to code[pos]; on mismatch set the sticky mismatch flag. Digit > 9 always mismatches, pulses err, sets disp_mode ERROR and leaves disp_digit unchanged. A legal digit sets disp_mode DIGIT and disp_digit to that digit. pos increments.
- ENTRY, last digit (pos == CODE_LEN-1 when the digit is accepted): with no mismatch, go to OPEN and clear fail_cnt. Otherwise increment fail_cnt. If the new value equals MAX_FAIL, go to LOCKOUT and load the timer with LOCKOUT_CYCLES-1; else go to CLOSED. pos and the mismatch flag clear in all cases.
- ENTRY, clear: pos 0, mismatch flag 0, fail_cnt unchanged. If clear and digit_valid arrive in the same cycle, clear wins and the digit is dropped.
- CLOSED: digit_valid and prog_req are ignored; clear returns to ENTRY.
- LOCKOUT: all inputs are ignored and the timer decrements each cycle. When the timer reads 0, go to ENTRY and clear fail_cnt.
- OPEN: clear goes to ENTRY. prog_req goes to PROG with pos 0. If both arrive in the same cycle, clear wins.
- PROG: each legal digit is written to the shadow code at pos and pos increments. After CODE_LEN digits the shadow is committed to code in one edge, then return to OPEN. An illegal digit or clear aborts: shadow discarded, err pulse, return to OPEN. The live code never changes mid-pass.
- disp_mode per state: OPEN in OPEN, CLOSED in CLOSED, LOCKED in LOCKOUT, PROG in PROG, DIGIT/ERROR in ENTRY.

## Timing
- All outputs are registered. The effect of a strobe sampled at edge N is visible after edge N.
- Decision latency: the final digit sampled at edge N gives OPEN/CLOSED/LOCKOUT after edge N.
- LOCKOUT is entered at edge N and exits to ENTRY at edge N+LOCKOUT_CYCLES.
- digit_valid held high counts one digit per cycle; no edge detection inside this block.
- rst_n low at any edge overrides every strobe and state, including mid-PROG (shadow discarded, code back to DEFAULT_CODE) and mid-LOCKOUT.
- err is high for exactly one cycle per event.

## Structure
- lock_pkg: state enum (ENTRY, OPEN, CLOSED, LOCKOUT, PROG), disp_mode enum, CODE_LEN, digit width 4, function is_legal_digit.
- Sub-module lock_code_store: live code register, shadow register, write port (pos, digit), commit, discard, and read of code[pos]. The FSM, counters and timer stay in lock_sequencer.

## Test plan
- Reset, then enter 7,0,3,2,6,2 -> state OPEN after the 6th strobe, unlocked 1, fail_cnt 0, disp_mode OPEN.
- Enter 7,0,3,2,6,3 -> CLOSED, fail_cnt 1; clear -> ENTRY, pos 0; enter 7,0,3,11,2,6 -> err pulse on the 11, disp_mode ERROR, then CLOSED, fail_cnt 2.
- Three wrong attempts -> LOCKOUT. Strobes during the 16 cycles are ignored. ENTRY appears exactly 16 edges after entry with fail_cnt 0.
- From OPEN: prog_req, then 1,2,3,4,5,6 -> OPEN with new code. clear, then 1,2,3,4,5,6 -> OPEN; 7,0,3,2,6,2 -> CLOSED.
- From PROG after 3 digits: digit 12 -> err, OPEN, old code still opens. Repeat with rst_n low mid-PROG -> ENTRY, DEFAULT_CODE works.
- ENTRY at pos 4: clear and digit_valid in the same cycle -> pos 0, digit dropped, mismatch flag cleared.
